array_multiplier_4x4: RTL and testbench
=======================================

Name: array_multiplier_4x4

Overview:
- Unsigned WIDTH x WIDTH array multiplier built from a carry-save grid of AND partial products and half/full-adder cells.
- Product is registered, so the block is a single-stage pipelined arithmetic unit for datapath use.
- The default configuration is 4x4 with an 8-bit product.
- A valid strobe accompanies each operand pair and each result.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH. Legal range is 2..16.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b are valid this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- p  output  2*WIDTH  registered product a*b, unsigned.
- out_valid  output  1  p holds a new product this cycle.

Behaviour:
- Reset:
  - rst_n low forces p=0 and out_valid=0 immediately, without waiting for a clock edge.
  - Outputs stay there while rst_n is low.
  - The first capture happens on the first rising clk after rst_n deasserts.
- Datapath:
  - Partial products pp[i][j] = a[i] & b[j].
  - Row 0 is reduced with half adders; each later row adds the shifted partial-product row to the previous row's sum/carry vector using full adders.
  - The MSB position of each row uses a half adder.
  - A final ripple row resolves the remaining carries.
  - The full result must equal the exact unsigned product a*b.
  - No truncation and no overflow are possible, since (2^W-1)^2 < 2^(2W).
- Timing:
  - The array is purely combinational.
  - Latency from in_valid sampled high to out_valid high is exactly 1 cycle; p is valid in that same cycle.
  - Throughput is 1 product per cycle; back-to-back in_valid produces back-to-back out_valid with no bubbles.
- Capture rules:
  - in_valid high: p <= a*b and out_valid <= 1.
  - in_valid low: p holds its previous value and out_valid <= 0.
  - out_valid is a one-cycle pulse per accepted operand pair. There is no backpressure.
- Boundary cases:
  - Either operand 0 gives p = 0.
  - Maximum operands give p = (2^W-1)^2; for W=4, 15*15 = 225 (8'hE1).
  - X/unknown operands while in_valid is low must not disturb p.
- Reset mid-operation: an operand pair accepted in the cycle before rst_n asserts is discarded. No out_valid pulse for it appears after reset releases.

Decomposition:
- Package array_mult_pkg holds the default width constant (4). No typedefs are required.
- Natural sub-module: mult_fa_cell, a 1-bit full adder with sum = x^y^ci and co = majority(x,y,ci).
  - Half-adder positions instantiate it with ci tied to 0.
  - The grid is built with generate loops over rows i and columns j.
- The output register and valid flop live in the top module.

Test Plan:
- Reset: hold rst_n=0 with random a/b and in_valid=1 -> p=0 and out_valid=0 throughout; first valid result appears 1 cycle after the first post-reset in_valid.
- Directed vectors, back-to-back one per cycle, in_valid=1 (W=4):
  - a=1, b=0 -> p=0
  - a=7, b=5 -> p=35 (00100011)
  - a=8, b=9 -> p=72 (01001000)
  - a=15, b=15 -> p=225 (11100001)
  - Each product appears one cycle later with out_valid=1 on every cycle.
- Hold: a=6, b=3 with in_valid=1, then change a/b with in_valid=0 for 3 cycles -> p stays 18 and out_valid is high for exactly 1 cycle.
- Exhaustive: all 256 (a,b) pairs streamed continuously -> every p equals a*b one cycle later, with no gaps in out_valid.
- Async reset mid-stream: assert rst_n between clock edges right after in_valid is accepted with a=15, b=15 -> p immediately 0 and out_valid 0; no stale 225 appears after release.
- Parameter sweep: WIDTH=8, a=255, b=255 -> p=65025 (16'hFE01); a=128, b=2 -> p=256.

Source files
------------

// File: rtl/array_mult_pkg.sv
// rtl/array_mult_pkg.sv - shared constants for the array multiplier
package array_mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/mult_fa_cell.sv
// rtl/mult_fa_cell.sv - 1-bit full adder cell; half adder when ci_i is tied low
module mult_fa_cell (
   input  logic x_i,
   input  logic y_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = x_i ^ y_i ^ ci_i;
   assign co_o = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);

endmodule

// File: rtl/array_multiplier_4x4.sv
// rtl/array_multiplier_4x4.sv - unsigned carry-save array multiplier with registered product
module array_multiplier_4x4
   import array_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   p,
   output logic                 out_valid
);

   // s[i][j] carries weight i+j, c[i][j] weight i+j+1; row 0 is the bare partial products
   logic [WIDTH-1:0][WIDTH-1:0] pp;
   logic [WIDTH-1:0][WIDTH-1:0] s;
   logic [WIDTH-1:0][WIDTH-1:0] c;
   logic [WIDTH-2:0]            rc;
   logic [2*WIDTH-1:0]          prod;

   logic [2*WIDTH-1:0] p_q, p_d;
   logic               out_valid_q, out_valid_d;

   genvar i, j, k;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_pp_row
         for (j = 0; j < WIDTH; j++) begin : g_pp_col
            assign pp[i][j] = a[i] & b[j];
         end
      end

      assign s[0] = pp[0];
      assign c[0] = '0;

      for (i = 1; i < WIDTH; i++) begin : g_row
         for (j = 0; j < WIDTH; j++) begin : g_col
            if (j < WIDTH-1) begin : g_mid
               mult_fa_cell u_fa (
                  .x_i  (pp[i][j]),
                  .y_i  (s[i-1][j+1]),
                  .ci_i (c[i-1][j]),
                  .s_o  (s[i][j]),
                  .co_o (c[i][j])
               );
            end else begin : g_msb
               mult_fa_cell u_ha (
                  .x_i  (pp[i][j]),
                  .y_i  (c[i-1][j]),
                  .ci_i (1'b0),
                  .s_o  (s[i][j]),
                  .co_o (c[i][j])
               );
            end
         end
      end

      for (i = 0; i < WIDTH; i++) begin : g_low_bits
         assign prod[i] = s[i][0];
      end

      // Final ripple row resolves the last sum/carry vector into the upper half
      for (k = 0; k < WIDTH-1; k++) begin : g_ripple
         if (k == 0) begin : g_first
            mult_fa_cell u_rca (
               .x_i  (s[WIDTH-1][k+1]),
               .y_i  (c[WIDTH-1][k]),
               .ci_i (1'b0),
               .s_o  (prod[WIDTH+k]),
               .co_o (rc[k])
            );
         end else begin : g_next
            mult_fa_cell u_rca (
               .x_i  (s[WIDTH-1][k+1]),
               .y_i  (c[WIDTH-1][k]),
               .ci_i (rc[k-1]),
               .s_o  (prod[WIDTH+k]),
               .co_o (rc[k])
            );
         end
      end
   endgenerate

   // Carry out of the top bit is always zero since (2^W-1)^2 < 2^(2W)
   assign prod[2*WIDTH-1] = c[WIDTH-1][WIDTH-1] ^ rc[WIDTH-2];

   always_comb begin
      p_d         = p_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         p_d         = prod;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign p         = p_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier_4x4.sv
// tb/tb_array_multiplier_4x4.sv - directed self-checking bench for the array multiplier
module tb_array_multiplier_4x4;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] p;
   logic       out_valid;

   logic        in_valid8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic [15:0] p8;
   logic        out_valid8;

   int chk_cnt;
   int pass_cnt;

   array_multiplier_4x4 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .p         (p),
      .out_valid (out_valid)
   );

   array_multiplier_4x4 #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .a         (a8),
      .b         (b8),
      .p         (p8),
      .out_valid (out_valid8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_valid8 = 1'b1;
      a8 = 8'd200;
      b8 = 8'd3;
      for (int n = 0; n < 4; n++) begin
         a = 4'($urandom_range(1, 15));
         b = 4'($urandom_range(1, 15));
         edge_settle();
         chk_cnt++;
         if (p !== 8'd0 || out_valid !== 1'b0)
            $display("FAIL reset_hold: p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
         else
            pass_cnt++;
      end
      chk_cnt++;
      if (p8 !== 16'd0 || out_valid8 !== 1'b0)
         $display("FAIL reset_hold_w8: p=%0d out_valid=%b, required p=0 out_valid=0", p8, out_valid8);
      else
         pass_cnt++;
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
      #3;
      rst_n = 1'b1;
      edge_settle();
      chk_cnt++;
      if (p !== 8'd0 || out_valid !== 1'b0)
         $display("FAIL reset_idle: p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
      else
         pass_cnt++;
      in_valid = 1'b1;
      a = 4'd3;
      b = 4'd5;
      edge_settle();
      in_valid = 1'b0;
      chk_cnt++;
      if (p !== 8'd15 || out_valid !== 1'b1)
         $display("FAIL reset_first: p=%0d out_valid=%b, required p=15 out_valid=1", p, out_valid);
      else
         pass_cnt++;
   endtask

   task automatic test_directed();
      logic [3:0] va [4];
      logic [3:0] vb [4];
      logic [7:0] vp [4];
      va = '{4'd1, 4'd7, 4'd8, 4'd15};
      vb = '{4'd0, 4'd5, 4'd9, 4'd15};
      vp = '{8'd0, 8'b0010_0011, 8'b0100_1000, 8'b1110_0001};
      for (int n = 0; n < 4; n++) begin
         in_valid = 1'b1;
         a = va[n];
         b = vb[n];
         edge_settle();
         chk_cnt++;
         if (p !== vp[n] || out_valid !== 1'b1)
            $display("FAIL directed_%0d: p=%0d out_valid=%b, required p=%0d out_valid=1",
                     n, p, out_valid, vp[n]);
         else
            pass_cnt++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_hold();
      in_valid = 1'b1;
      a = 4'd6;
      b = 4'd3;
      edge_settle();
      chk_cnt++;
      if (p !== 8'd18 || out_valid !== 1'b1)
         $display("FAIL hold_capture: p=%0d out_valid=%b, required p=18 out_valid=1", p, out_valid);
      else
         pass_cnt++;
      in_valid = 1'b0;
      for (int n = 0; n < 3; n++) begin
         a = (n == 1) ? 4'bxxxx : 4'(n + 9);
         b = (n == 1) ? 4'bxxxx : 4'(n + 11);
         edge_settle();
         chk_cnt++;
         if (p !== 8'd18 || out_valid !== 1'b0)
            $display("FAIL hold_cycle_%0d: p=%0d out_valid=%b, required p=18 out_valid=0",
                     n, p, out_valid);
         else
            pass_cnt++;
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0] exp_p;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            in_valid = 1'b1;
            a = 4'(ia);
            b = 4'(ib);
            exp_p = 8'(ia * ib);
            edge_settle();
            chk_cnt++;
            if (p !== exp_p || out_valid !== 1'b1)
               $display("FAIL exhaustive_%0dx%0d: p=%0d out_valid=%b, required p=%0d out_valid=1",
                        ia, ib, p, out_valid, exp_p);
            else
               pass_cnt++;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      a = 4'd15;
      b = 4'd15;
      edge_settle();
      in_valid = 1'b0;
      chk_cnt++;
      if (p !== 8'd225 || out_valid !== 1'b1)
         $display("FAIL async_pre: p=%0d out_valid=%b, required p=225 out_valid=1", p, out_valid);
      else
         pass_cnt++;
      #1;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (p !== 8'd0 || out_valid !== 1'b0)
         $display("FAIL async_assert: p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
      else
         pass_cnt++;
      edge_settle();
      #2;
      rst_n = 1'b1;
      for (int n = 0; n < 2; n++) begin
         edge_settle();
         chk_cnt++;
         if (p !== 8'd0 || out_valid !== 1'b0)
            $display("FAIL async_release_%0d: p=%0d out_valid=%b, required p=0 out_valid=0",
                     n, p, out_valid);
         else
            pass_cnt++;
      end
   endtask

   task automatic test_width8();
      in_valid8 = 1'b1;
      a8 = 8'd255;
      b8 = 8'd255;
      edge_settle();
      chk_cnt++;
      if (p8 !== 16'hFE01 || out_valid8 !== 1'b1)
         $display("FAIL w8_max: p=%0d out_valid=%b, required p=65025 out_valid=1", p8, out_valid8);
      else
         pass_cnt++;
      a8 = 8'd128;
      b8 = 8'd2;
      edge_settle();
      in_valid8 = 1'b0;
      chk_cnt++;
      if (p8 !== 16'd256 || out_valid8 !== 1'b1)
         $display("FAIL w8_shift: p=%0d out_valid=%b, required p=256 out_valid=1", p8, out_valid8);
      else
         pass_cnt++;
      edge_settle();
      chk_cnt++;
      if (p8 !== 16'd256 || out_valid8 !== 1'b0)
         $display("FAIL w8_idle: p=%0d out_valid=%b, required p=256 out_valid=0", p8, out_valid8);
      else
         pass_cnt++;
   endtask

   initial begin
      chk_cnt   = 0;
      pass_cnt  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
      a  = '0;
      b  = '0;
      a8 = '0;
      b8 = '0;
      test_reset();
      test_directed();
      test_hold();
      test_exhaustive();
      test_async_reset();
      test_width8();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
